hello_scroller: RTL

Sequencing controller for the Lab 1 character datapath. Holds an 8-entry ring of 3-bit character codes spelling "HELLO" plus three blanks. On a prescaled tick, rotates that ring across six displays. Drives six downstream 3-bit character-to-7-segment decoders, which map code 000 to H, 001 to E, 010 to L, 011 to O and 1xx to blank. Pushbuttons give run/pause, direction and single-step control.

---
 rtl/hello_scroller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hello_scroller.sv
// Scrolls "HELLO" plus three blanks across six 3-bit character displays.
// Pushbuttons give run/pause, direction and single-step control; the scroll rate comes from a prescaler.
module hello_scroller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [0:0]  SW,
    output logic [17:0] char_codes,
    output logic [9:0]  LEDR
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(TICK_DIV / 4 - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;

    logic             rst_n;
    logic [2:0]       sync1_reg;
    logic [2:0]       sync2_reg;
    logic [2:0]       prev_reg;
    logic [2:0]       press;
    logic             run_pulse;
    logic             dir_pulse;
    logic             step_pulse;

    logic [1:0]       state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_last;
    logic             tick;
    logic [2:0]       ptr_adv;

    assign rst_n = KEY[0];

    // KEY[3:1] -> two-flop synchronizer -> previous-value register
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            sync1_reg <= 3'b111;
            sync2_reg <= 3'b111;
            prev_reg  <= 3'b111;
        end else begin
            sync1_reg <= KEY[3:1];
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign press      = prev_reg & ~sync2_reg;
    assign run_pulse  = press[0];
    assign dir_pulse  = press[1];
    assign step_pulse = press[2];

    // Speed select is a raw level; the >= compare absorbs a mid-count switch.
    assign cnt_last = SW[0] ? LAST_FAST : LAST_SLOW;
    assign tick     = (cnt_reg >= cnt_last);
    assign ptr_adv  = dir_reg ? (ptr_reg - 3'd1) : (ptr_reg + 3'd1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg ^ dir_pulse;
        case (state_reg)
            ST_RUN: begin
                if (run_pulse) begin
                    state_next = ST_PAUSE;
                    cnt_next   = '0;
                end else if (tick) begin
                    ptr_next = ptr_adv;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PAUSE: begin
                cnt_next = '0;
                if (run_pulse)
                    state_next = ST_RUN;
                else if (step_pulse)
                    state_next = ST_STEP;
            end
            ST_STEP: begin
                cnt_next   = '0;
                ptr_next   = ptr_adv;
                state_next = ST_PAUSE;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            ptr_reg   <= 3'd0;
            dir_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            dir_reg   <= dir_next;
            cnt_reg   <= cnt_next;
        end
    end

    function automatic logic [2:0] ring_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b000;
            3'd1:    code = 3'b001;
            3'd2:    code = 3'b010;
            3'd3:    code = 3'b010;
            3'd4:    code = 3'b011;
            default: code = 3'b100;
        endcase
        return code;
    endfunction

    // Display gi shows ring[(ptr + 5 - gi) mod 8]; gi = 5 is the leftmost digit.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_disp
            assign char_codes[3*gi+2 -: 3] = ring_code(ptr_reg + 3'(5 - gi));
        end
    endgenerate

    assign LEDR = {5'd0, ptr_reg, dir_reg, (state_reg == ST_RUN)};

endmodule
